// File: rtl/cvg_slew_pkg.sv
// Shared types and constants for the control-voltage slewer.
// Readback of targets/STEP is enabled by defining CVG_SLEW_READBACK_EN.
package cvg_slew_pkg;

    localparam int NUM_CH = 6;

    localparam logic [2:0] CH_OFFSET = 3'd0;
    localparam logic [2:0] CH_DUTYS  = 3'd1;
    localparam logic [2:0] CH_GAINV  = 3'd2;
    localparam logic [2:0] CH_SQVL   = 3'd3;
    localparam logic [2:0] CH_SQVT   = 3'd4;
    localparam logic [2:0] CH_SPARE  = 3'd5;

    localparam logic [2:0] ADDR_STEP = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    typedef logic [11:0] code_t;

endpackage

// File: rtl/cvg_slew_tick_div.sv
// Free-running divider: Tick is high for one cycle every TICK_DIV clocks,
// in the cycle where the count sits at TICK_DIV-1.
module cvg_slew_tick_div #(
    parameter int TICK_DIV = 54
) (
    input  logic Clock,
    input  logic Reset,
    output logic Tick
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = (count_q == 16'(TICK_DIV - 1)) ? 16'd0 : count_q + 16'd1;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Tick = (count_q == 16'(TICK_DIV - 1));

endmodule

// File: rtl/cvg_ctrl_voltage_slewer.sv
// Six-channel control-code slewer: one shared step/clamp datapath visits each
// channel once per tick. CVG_SLEW_READBACK_EN adds a registered readback port.
module cvg_ctrl_voltage_slewer
    import cvg_slew_pkg::*;
#(
    parameter int          TICK_DIV   = 54,
    parameter logic [11:0] STEP_RESET = 12'h001
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Wr_En,
    input  logic [2:0]  Wr_Addr,
    input  logic [11:0] Wr_Data,
    output logic [11:0] OFFSET_VU,
    output logic [11:0] DUTYS_VU,
    output logic [11:0] GAINV_VU,
    output logic [11:0] SQVL_VU,
    output logic [11:0] SQVT_VU,
    output logic [11:0] SPARE_VU,
    output logic        Settled,
    output logic        Busy
`ifdef CVG_SLEW_READBACK_EN
    ,
    input  logic [2:0]  Rd_Addr,
    output logic [11:0] Rd_Data
`endif
);

    state_e       state_q, state_d;
    logic [2:0]   ch_q, ch_d;
    code_t        step_q, step_d;
    code_t        tgt_q [NUM_CH];
    code_t        tgt_d [NUM_CH];
    code_t        cur_q [NUM_CH];
    code_t        cur_d [NUM_CH];
    logic         settled_q, settled_d;
    logic         tick;

    code_t              sel_cur, sel_tgt, mag, next_code;
    logic signed [12:0] diff;

    cvg_slew_tick_div #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_div (
        .Clock(Clock),
        .Reset(Reset),
        .Tick (tick)
    );

    // Shared datapath: move toward target by STEP, landing exactly on it when closer.
    always_comb begin
        sel_cur = cur_q[ch_q];
        sel_tgt = tgt_q[ch_q];
        diff    = {1'b0, sel_tgt} - {1'b0, sel_cur};
        mag     = diff[12] ? 12'(-diff) : 12'(diff);
        if (step_q == 12'h000 || step_q >= mag) begin
            next_code = sel_tgt;
        end else if (diff[12]) begin
            next_code = sel_cur - step_q;
        end else begin
            next_code = sel_cur + step_q;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tgt_d  = tgt_q;
        cur_d  = cur_q;
        step_d = step_q;
        if (Wr_En) begin
            if (Wr_Addr == ADDR_STEP) begin
                step_d = Wr_Data;
            end else if (Wr_Addr < ADDR_STEP) begin
                tgt_d[Wr_Addr] = Wr_Data;
            end
        end
        if (state_q == SCAN) begin
            cur_d[ch_q] = next_code;
        end
        settled_d = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_q[i] != tgt_q[i]) begin
                settled_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    ch_d    = CH_OFFSET;
                end
            end
            SCAN: begin
                if (ch_q == CH_SPARE) begin
                    state_d = IDLE;
                    ch_d    = CH_OFFSET;
                end else begin
                    ch_d = ch_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = CH_OFFSET;
            end
        endcase
    end

    always_comb begin
        Busy = (state_q == SCAN);
    end

    // NOTE: the code/target arrays are only six registers, so they take the async reset like any other state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            ch_q      <= CH_OFFSET;
            step_q    <= STEP_RESET;
            settled_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= 12'h000;
                cur_q[i] <= 12'h000;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            step_q    <= step_d;
            settled_q <= settled_d;
            tgt_q     <= tgt_d;
            cur_q     <= cur_d;
        end
    end

    assign OFFSET_VU = cur_q[CH_OFFSET];
    assign DUTYS_VU  = cur_q[CH_DUTYS];
    assign GAINV_VU  = cur_q[CH_GAINV];
    assign SQVL_VU   = cur_q[CH_SQVL];
    assign SQVT_VU   = cur_q[CH_SQVT];
    assign SPARE_VU  = cur_q[CH_SPARE];
    assign Settled   = settled_q;

`ifdef CVG_SLEW_READBACK_EN
    code_t rd_q, rd_d;

    always_comb begin
        rd_d = 12'h000;
        if (Rd_Addr == ADDR_STEP) begin
            rd_d = step_q;
        end else if (Rd_Addr < ADDR_STEP) begin
            rd_d = tgt_q[Rd_Addr];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_q <= 12'h000;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign Rd_Data = rd_q;
`endif

endmodule

// File: tb/tb_cvg_ctrl_voltage_slewer.sv
// Directed bench for cvg_ctrl_voltage_slewer; readback checks are built when
// CVG_SLEW_READBACK_EN is defined.
module tb_cvg_ctrl_voltage_slewer;

    localparam int TICK_DIV = 16;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Wr_En;
    logic [2:0]  Wr_Addr;
    logic [11:0] Wr_Data;
    logic [11:0] OFFSET_VU, DUTYS_VU, GAINV_VU, SQVL_VU, SQVT_VU, SPARE_VU;
    logic        Settled, Busy;
`ifdef CVG_SLEW_READBACK_EN
    logic [2:0]  Rd_Addr;
    logic [11:0] Rd_Data;
`endif

    typedef struct {
        string       tag;
        int          ch;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;

    cvg_ctrl_voltage_slewer #(
        .TICK_DIV  (TICK_DIV),
        .STEP_RESET(12'h001)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Wr_En    (Wr_En),
        .Wr_Addr  (Wr_Addr),
        .Wr_Data  (Wr_Data),
        .OFFSET_VU(OFFSET_VU),
        .DUTYS_VU (DUTYS_VU),
        .GAINV_VU (GAINV_VU),
        .SQVL_VU  (SQVL_VU),
        .SQVT_VU  (SQVT_VU),
        .SPARE_VU (SPARE_VU),
        .Settled  (Settled),
        .Busy     (Busy)
`ifdef CVG_SLEW_READBACK_EN
        ,
        .Rd_Addr  (Rd_Addr),
        .Rd_Data  (Rd_Data)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 12'h%03h expected 12'h%03h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] out_of(input int ch);
        case (ch)
            0:       return OFFSET_VU;
            1:       return DUTYS_VU;
            2:       return GAINV_VU;
            3:       return SQVL_VU;
            4:       return SQVT_VU;
            5:       return SPARE_VU;
            default: return 12'hxxx;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Drives one write cycle starting at the current falling edge.
    task automatic wr(input logic [2:0] addr, input logic [11:0] data);
        Wr_En   = 1'b1;
        Wr_Addr = addr;
        Wr_Data = data;
        @(negedge Clock);
        Wr_En   = 1'b0;
    endtask

    task automatic push_exp(input string tag, input int ch, input logic [11:0] exp);
        exp_t e;
        e.tag = tag;
        e.ch  = ch;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 12'd0, 12'd1);
        end else begin
            e = sb.pop_front();
            check(e.tag, out_of(e.ch), e.exp);
        end
    endtask

    // Returns at the falling edge of the first SCAN cycle (channel 0 in flight).
    task automatic wait_scan_start();
        int n = 0;
        while (Busy && n < 4 * TICK_DIV) begin
            @(negedge Clock);
            n++;
        end
        while (!Busy && n < 4 * TICK_DIV) begin
            @(negedge Clock);
            n++;
        end
        check("scan_start", {11'd0, Busy}, 12'd1);
    endtask

    initial begin
        int n;
        Reset   = 1'b1;
        Wr_En   = 1'b0;
        Wr_Addr = 3'd0;
        Wr_Data = 12'h000;
`ifdef CVG_SLEW_READBACK_EN
        Rd_Addr = 3'd0;
`endif
        cyc(2);
        for (int i = 0; i < 6; i++) check($sformatf("rst_out%0d", i), out_of(i), 12'h000);
        check("rst_settled", {11'd0, Settled}, 12'd1);
        check("rst_busy", {11'd0, Busy}, 12'd0);
`ifdef CVG_SLEW_READBACK_EN
        check("rst_rd", Rd_Data, 12'h000);
`endif
        Reset = 1'b0;

        // Up-ramp on OFFSET with STEP=0x010.
        wr(3'd6, 12'h010);
        wr(3'd0, 12'h035);
        check("settled_hold", {11'd0, Settled}, 12'd1);
        cyc(1);
        check("settled_fall", {11'd0, Settled}, 12'd0);
        push_exp("ramp_up0", 0, 12'h010);
        push_exp("ramp_up1", 0, 12'h020);
        push_exp("ramp_up2", 0, 12'h030);
        push_exp("ramp_up3", 0, 12'h035);
        for (int i = 0; i < 4; i++) begin
            wait_scan_start();
            cyc(1);
            pop_check();
            if (i == 3) begin
                check("settled_lag", {11'd0, Settled}, 12'd0);
                cyc(1);
                check("settled_rise", {11'd0, Settled}, 12'd1);
            end
        end
        for (int i = 1; i < 6; i++) check($sformatf("ramp_other%0d", i), out_of(i), 12'h000);
        cyc(4);

        // Down-ramp on SQVT with clamp at zero.
        wr(3'd6, 12'h000);
        wr(3'd4, 12'h035);
        push_exp("sqvt_preload", 4, 12'h035);
        wait_scan_start();
        cyc(5);
        pop_check();
        cyc(1);
        wr(3'd6, 12'h020);
        wr(3'd4, 12'h000);
        push_exp("ramp_dn0", 4, 12'h015);
        push_exp("ramp_dn1", 4, 12'h000);
        push_exp("ramp_dn_nowrap", 4, 12'h000);
        for (int i = 0; i < 3; i++) begin
            wait_scan_start();
            cyc(5);
            pop_check();
            cyc(1);
        end

        // Jump mode on SPARE, plus scan length.
        wr(3'd6, 12'h000);
        wr(3'd5, 12'hFFF);
        wait_scan_start();
        n = 0;
        while (Busy && n < 20) begin
            n++;
            if (n == 6) check("spare_pre", SPARE_VU, 12'h000);
            @(negedge Clock);
        end
        check("busy_len", 12'(n), 12'd6);
        check("spare_jump", SPARE_VU, 12'hFFF);

        // Target write colliding with channel 2's scan slot, and an address-7 write.
        wr(3'd6, 12'hFFF);
        wait_scan_start();
        cyc(2);
        wr(3'd2, 12'h100);
        wr(3'd7, 12'h001);
        cyc(2);
        check("gainv_collide", GAINV_VU, 12'h000);
        push_exp("final_offset", 0, 12'h035);
        push_exp("final_dutys", 1, 12'h000);
        push_exp("final_gainv", 2, 12'h100);
        push_exp("final_sqvl", 3, 12'h000);
        push_exp("final_sqvt", 4, 12'h000);
        push_exp("final_spare", 5, 12'hFFF);
        wait_scan_start();
        cyc(6);
        for (int i = 0; i < 6; i++) pop_check();
        cyc(1);
        check("final_settled", {11'd0, Settled}, 12'd1);

`ifdef CVG_SLEW_READBACK_EN
        wr(3'd3, 12'hABC);
        Rd_Addr = 3'd3;
        cyc(1);
        check("rd_target3", Rd_Data, 12'hABC);
        Rd_Addr = 3'd6;
        cyc(1);
        check("rd_step", Rd_Data, 12'hFFF);
        Rd_Addr = 3'd7;
        cyc(1);
        check("rd_addr7", Rd_Data, 12'h000);
`endif

        // Asynchronous reset in the middle of a scan.
        wait_scan_start();
        cyc(2);
        Reset = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) check($sformatf("midrst_out%0d", i), out_of(i), 12'h000);
        check("midrst_settled", {11'd0, Settled}, 12'd1);
        check("midrst_busy", {11'd0, Busy}, 12'd0);
`ifdef CVG_SLEW_READBACK_EN
        check("midrst_rd", Rd_Data, 12'h000);
`endif
        @(negedge Clock);
        Reset = 1'b0;
        n = 0;
        while (!Busy && n < 4 * TICK_DIV) begin
            @(negedge Clock);
            n++;
        end
        check("tick_restart", 12'(n), 12'(TICK_DIV));
        cyc(6);
        check("postrst_offset", OFFSET_VU, 12'h000);
        check("postrst_gainv", GAINV_VU, 12'h000);
        check("postrst_settled", {11'd0, Settled}, 12'd1);
        wr(3'd0, 12'h003);
        push_exp("step_reset_val", 0, 12'h001);
        wait_scan_start();
        cyc(1);
        pop_check();

        check("sb_drained", 12'(sb.size()), 12'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
